// File: rtl/wos_pkg.sv
// Shared types and constants for the weighted-order-statistics address sequencer.
package wos_pkg;

    localparam int WORD_DEFAULT  = 8;
    localparam int MAX_N_DEFAULT = 3;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        SHIFT,
        WRITE,
        DONE
    } state_t;

    // Address width large enough for an h*w image plus its result region.
    function automatic int calc_aw(input int word);
        return 2 * word + 1;
    endfunction

endpackage

// File: rtl/wos_addr_gen.sv
// Incremental address registers: window-column base, tap read pointer and output pointer.
// No multipliers: the result base h*w is formed by shift-add at frame start.
module wos_addr_gen
    import wos_pkg::*;
#(
    parameter int  WORD = WORD_DEFAULT,
    localparam int AW   = calc_aw(WORD)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [WORD-1:0] h_in,
    input  logic [WORD-1:0] w_in,
    input  logic [WORD-1:0] w_cfg,
    input  logic            load,
    input  logic            tap_step,
    input  logic            col_step,
    input  logic            out_step,
    output logic [AW-1:0]   rd_ptr,
    output logic [AW-1:0]   pix_next,
    output logic [AW-1:0]   out_ptr
);

    logic [AW-1:0] pix_q, pix_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] out_q, out_d;
    logic [AW-1:0] area;

    always_comb begin
        area = '0;
        for (int i = 0; i < WORD; i++) begin
            if (h_in[i]) begin
                area = area + (AW'(w_in) << i);
            end
        end
    end

    // pix tracks y*w + x; wrapping x to 0 on y++ is the same as adding one.
    always_comb begin
        pix_d = pix_q;
        rd_d  = rd_q;
        out_d = out_q;
        if (load) begin
            pix_d = '0;
            rd_d  = AW'(w_in);
            out_d = area;
        end else begin
            if (tap_step) begin
                rd_d = rd_q + AW'(w_cfg);
            end
            if (col_step) begin
                pix_d = pix_q + 1'b1;
                rd_d  = pix_q + 1'b1 + AW'(w_cfg);
            end
            if (out_step) begin
                out_d = out_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pix_q <= '0;
            rd_q  <= '0;
            out_q <= '0;
        end else begin
            pix_q <= pix_d;
            rd_q  <= rd_d;
            out_q <= out_d;
        end
    end

    assign rd_ptr   = rd_q;
    assign pix_next = pix_q + 1'b1;
    assign out_ptr  = out_q;

endmodule

// File: rtl/wos_address_handler.sv
// Sliding-window read/write address sequencer for the WOS filter; all outputs registered.
// Define ADDRESS_HANDLER_CFG_CHECK_EN to make run ignore invalid h/w/n configurations.
module wos_address_handler
    import wos_pkg::*;
#(
    parameter int  WORD  = WORD_DEFAULT,
    parameter int  MAX_N = MAX_N_DEFAULT,
    localparam int AW    = calc_aw(WORD)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [WORD-1:0] h,
    input  logic [WORD-1:0] w,
    input  logic [WORD-1:0] n,
    input  logic            run,
    output logic [AW-1:0]   address,
    output logic            r_en,
    output logic            w_en,
    output logic            kernel_newline,
    output logic            kernel_clk,
    output logic            kernel_running
);

    state_t          state_q, state_d;
    logic [WORD-1:0] h_q, h_d, w_q, w_d, n_q, n_d;
    logic [WORD-1:0] x_q, x_d, y_q, y_d, k_q, k_d;
    logic [AW-1:0]   address_q, address_d;
    logic            r_en_q, r_en_d, w_en_q, w_en_d;
    logic            newline_q, newline_d, kclk_q, kclk_d, running_q, running_d;

    logic            cfg_ok, last_tap, advance;
    logic            load, tap_step, col_step, out_step;
    logic [WORD:0]   x_inc, y_next;
    logic [AW-1:0]   rd_ptr, pix_next, out_ptr;

`ifdef ADDRESS_HANDLER_CFG_CHECK_EN
    assign cfg_ok = (n != '0) && (n <= WORD'(MAX_N)) && (n <= h) && (n <= w);
`else
    assign cfg_ok = 1'b1;
`endif

    // MAX_N also caps the tap count so an unchecked oversize n cannot stall READ.
    assign last_tap = (k_q == n_q - 1'b1) || (k_q == WORD'(MAX_N - 1));
    assign x_inc    = {1'b0, x_q} + 1'b1;

    wos_addr_gen #(.WORD(WORD)) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .h_in     (h),
        .w_in     (w),
        .w_cfg    (w_q),
        .load     (load),
        .tap_step (tap_step),
        .col_step (col_step),
        .out_step (out_step),
        .rd_ptr   (rd_ptr),
        .pix_next (pix_next),
        .out_ptr  (out_ptr)
    );

    // Outputs are computed for the state being entered, so they line up with it.
    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        w_d       = w_q;
        n_d       = n_q;
        x_d       = x_q;
        y_d       = y_q;
        k_d       = k_q;
        address_d = address_q;
        r_en_d    = 1'b0;
        w_en_d    = 1'b0;
        kclk_d    = 1'b0;
        newline_d = 1'b0;
        load      = 1'b0;
        tap_step  = 1'b0;
        col_step  = 1'b0;
        out_step  = 1'b0;
        advance   = 1'b0;
        y_next    = {1'b0, y_q};

        unique case (state_q)
            IDLE: begin
                if (run && cfg_ok) begin
                    state_d   = READ;
                    h_d       = h;
                    w_d       = w;
                    n_d       = n;
                    x_d       = '0;
                    y_d       = '0;
                    k_d       = '0;
                    load      = 1'b1;
                    r_en_d    = 1'b1;
                    address_d = '0;
                end
            end
            READ: begin
                if (last_tap) begin
                    state_d   = SHIFT;
                    k_d       = '0;
                    kclk_d    = 1'b1;
                    newline_d = (x_q == '0);
                end else begin
                    k_d       = k_q + 1'b1;
                    tap_step  = 1'b1;
                    r_en_d    = 1'b1;
                    address_d = rd_ptr;
                end
            end
            SHIFT: begin
                if (x_inc >= {1'b0, n_q}) begin
                    state_d   = WRITE;
                    w_en_d    = 1'b1;
                    address_d = out_ptr;
                    out_step  = 1'b1;
                end else begin
                    advance = 1'b1;
                end
            end
            WRITE:   advance = 1'b1;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (advance) begin
            col_step = 1'b1;
            if (x_inc == {1'b0, w_q}) begin
                x_d    = '0;
                y_next = {1'b0, y_q} + 1'b1;
            end else begin
                x_d = x_inc[WORD-1:0];
            end
            y_d = y_next[WORD-1:0];
            if (y_next + {1'b0, n_q} > {1'b0, h_q}) begin
                state_d = DONE;
            end else begin
                state_d   = READ;
                k_d       = '0;
                r_en_d    = 1'b1;
                address_d = pix_next;
            end
        end

        running_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            h_q       <= '0;
            w_q       <= '0;
            n_q       <= '0;
            x_q       <= '0;
            y_q       <= '0;
            k_q       <= '0;
            address_q <= '0;
            r_en_q    <= 1'b0;
            w_en_q    <= 1'b0;
            kclk_q    <= 1'b0;
            newline_q <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            w_q       <= w_d;
            n_q       <= n_d;
            x_q       <= x_d;
            y_q       <= y_d;
            k_q       <= k_d;
            address_q <= address_d;
            r_en_q    <= r_en_d;
            w_en_q    <= w_en_d;
            kclk_q    <= kclk_d;
            newline_q <= newline_d;
            running_q <= running_d;
        end
    end

    assign address        = address_q;
    assign r_en           = r_en_q;
    assign w_en           = w_en_q;
    assign kernel_clk     = kclk_q;
    assign kernel_newline = newline_q;
    assign kernel_running = running_q;

endmodule

// File: tb/tb_wos_address_handler.sv
// Self-checking bench: per-cycle comparison against a loop-level model of the window walk.
module tb_wos_address_handler;
    import wos_pkg::*;

    localparam int WORD = 8;
    localparam int AW   = calc_aw(WORD);

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            run = 1'b0;
    logic [WORD-1:0] h = '0, w = '0, n = '0;
    logic [AW-1:0]   address;
    logic            r_en, w_en, kernel_newline, kernel_clk, kernel_running;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic          r_en;
        logic          w_en;
        logic          kclk;
        logic          knl;
        logic          running;
        logic [AW-1:0] addr;
    } obs_t;

    obs_t exp_q[$];

    always #5 clk = ~clk;

    wos_address_handler #(.WORD(WORD), .MAX_N(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .h              (h),
        .w              (w),
        .n              (n),
        .run            (run),
        .address        (address),
        .r_en           (r_en),
        .w_en           (w_en),
        .kernel_newline (kernel_newline),
        .kernel_clk     (kernel_clk),
        .kernel_running (kernel_running)
    );

    // mask=1 ignores the address when no strobe is active
    function automatic obs_t sample(input bit mask);
        obs_t o;
        o.r_en    = r_en;
        o.w_en    = w_en;
        o.kclk    = kernel_clk;
        o.knl     = kernel_newline;
        o.running = kernel_running;
        o.addr    = (mask && !r_en && !w_en) ? '0 : address;
        return o;
    endfunction

    function automatic obs_t mk(input bit re, input bit we, input bit kc, input bit nl,
                                input bit rn, input int a);
        obs_t o;
        o.r_en = re; o.w_en = we; o.kclk = kc; o.knl = nl; o.running = rn;
        o.addr = AW'(a);
        return o;
    endfunction

    // Reference: nested loops over output rows, columns and taps.
    function automatic void build_model(input int hh, input int ww, input int nn);
        exp_q.delete();
        for (int y = 0; y <= hh - nn; y++) begin
            for (int x = 0; x < ww; x++) begin
                for (int k = 0; k < nn; k++)
                    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, (y + k) * ww + x));
                exp_q.push_back(mk(1'b0, 1'b0, 1'b1, x == 0, 1'b1, 0));
                if (x >= nn - 1)
                    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                                       hh * ww + y * (ww - nn + 1) + (x - nn + 1)));
            end
        end
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0));
    endfunction

    task automatic report(input string tag, input int cyc, input obs_t got, input obs_t exp);
        $display("FAIL %s cyc %0d: got r_en=%b w_en=%b kclk=%b nl=%b run=%b addr=%0d, expected r_en=%b w_en=%b kclk=%b nl=%b run=%b addr=%0d",
                 tag, cyc, got.r_en, got.w_en, got.kclk, got.knl, got.running, got.addr,
                 exp.r_en, exp.w_en, exp.kclk, exp.knl, exp.running, exp.addr);
    endtask

    task automatic run_frame(input string tag, input int hh, input int ww, input int nn,
                             input bit perturb, output int nw, output int first_wa,
                             output int last_wa);
        obs_t got;
        int   run_cycles = 0;
        int   exp_cycles;
        nw = 0; first_wa = -1; last_wa = -1;
        build_model(hh, ww, nn);
        exp_cycles = (hh - nn + 1) * (ww * (nn + 1) + (ww - nn + 1)) + 1;
        @(negedge clk);
        h = WORD'(hh); w = WORD'(ww); n = WORD'(nn); run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (perturb) begin
                h   = WORD'($urandom);
                w   = WORD'($urandom);
                n   = WORD'($urandom_range(0, 7));
                run = 1'($urandom_range(0, 1));
            end
            got = sample(1'b1);
            checks++;
            if (got !== exp_q[i]) begin
                errors++;
                report(tag, i, got, exp_q[i]);
            end
            if (got.running === 1'b1) run_cycles++;
            if (got.w_en === 1'b1) begin
                if (nw == 0) first_wa = int'(got.addr);
                last_wa = int'(got.addr);
                nw++;
            end
            @(negedge clk);
        end
        run = 1'b0;
        got = sample(1'b1);
        checks++;
        if (got !== obs_t'('0)) begin
            errors++;
            report({tag, "_idle_after"}, exp_q.size(), got, obs_t'('0));
        end
        checks++;
        if (run_cycles != exp_cycles) begin
            errors++;
            $display("FAIL %s_running_cycles: got %0d, expected %0d", tag, run_cycles, exp_cycles);
        end
        $display("frame %s h=%0d w=%0d n=%0d writes=%0d running=%0d", tag, hh, ww, nn, nw, run_cycles);
    endtask

    task automatic expect_int(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic test_reset();
        obs_t got;
        rst = 1'b0; run = 1'b1; h = 8'd10; w = 8'd10; n = 8'd3;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            got = sample(1'b0);
            checks++;
            if (got !== obs_t'('0)) begin
                errors++;
                report("reset_hold", i, got, obs_t'('0));
            end
        end
        run = 1'b0; rst = 1'b1;
        @(negedge clk);
        got = sample(1'b0);
        checks++;
        if (got !== obs_t'('0)) begin
            errors++;
            report("reset_release", 0, got, obs_t'('0));
        end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        int nw, fw, lw;
        run_frame("basic_10x10_n3", 10, 10, 3, 1'b0, nw, fw, lw);
        expect_int("basic_first_write", fw, 100);
        expect_int("basic_last_write", lw, 163);
        expect_int("basic_write_count", nw, 64);
    endtask

    task automatic test_boundaries();
        int nw, fw, lw;
        run_frame("n_eq_h_eq_w_3", 3, 3, 3, 1'b0, nw, fw, lw);
        expect_int("3x3_write_count", nw, 1);
        expect_int("3x3_write_addr", fw, 9);
        run_frame("n1_2x2", 2, 2, 1, 1'b0, nw, fw, lw);
        expect_int("n1_write_count", nw, 4);
        expect_int("n1_first_write", fw, 4);
        expect_int("n1_last_write", lw, 7);
        run_frame("n_eq_w", 6, 3, 3, 1'b0, nw, fw, lw);
        expect_int("n_eq_w_write_count", nw, 4);
        run_frame("n_eq_h", 3, 7, 3, 1'b0, nw, fw, lw);
        expect_int("n_eq_h_write_count", nw, 5);
    endtask

    task automatic test_random();
        int nw, fw, lw, hh, ww, nn;
        for (int t = 0; t < 10; t++) begin
            nn = $urandom_range(1, 3);
            hh = $urandom_range(nn, 9);
            ww = $urandom_range(nn, 9);
            run_frame("random", hh, ww, nn, 1'b1, nw, fw, lw);
            expect_int("random_write_count", nw, (hh - nn + 1) * (ww - nn + 1));
        end
    endtask

    task automatic test_cfg_check();
`ifdef ADDRESS_HANDLER_CFG_CHECK_EN
        obs_t got;
        int   cfgs[3][3] = '{'{10, 10, 4}, '{10, 2, 3}, '{10, 10, 0}};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            h = WORD'(cfgs[c][0]); w = WORD'(cfgs[c][1]); n = WORD'(cfgs[c][2]); run = 1'b1;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                got = sample(1'b1);
                checks++;
                if (got !== obs_t'('0)) begin
                    errors++;
                    report("cfg_reject", c * 10 + i, got, obs_t'('0));
                end
            end
            run = 1'b0;
            $display("cfg_check h=%0d w=%0d n=%0d rejected", cfgs[c][0], cfgs[c][1], cfgs[c][2]);
        end
`endif
    endtask

    task automatic test_mid_reset();
        obs_t got;
        int   nw, fw, lw;
        @(negedge clk);
        h = 8'd10; w = 8'd10; n = 8'd3; run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (kernel_running !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_pre_running: got %b, expected 1", kernel_running);
        end
        rst = 1'b0;
        @(negedge clk);
        got = sample(1'b0);
        checks++;
        if (got !== obs_t'('0)) begin
            errors++;
            report("mid_reset", 0, got, obs_t'('0));
        end
        rst = 1'b1;
        run_frame("after_mid_reset", 10, 10, 3, 1'b0, nw, fw, lw);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_cfg_check();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
